// File: rtl/risc_v_mike_imem_ctrl_if.sv
// rtl/risc_v_mike_imem_ctrl_if.sv - load stream, memory and fetch bus of the imem controller
interface risc_v_mike_imem_ctrl_if #(
  parameter int IMEM_DEPTH = 1024,
  parameter int AW         = $clog2(IMEM_DEPTH)
);
  // load control and boot word stream
  logic          load_start;
  logic [AW:0]   load_len;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_ready;
  // instruction memory write port
  logic          imem_wr_en;
  logic [AW-1:0] imem_wr_addr;
  logic [31:0]   imem_wr_data;
  // fetch qualification and core control
  logic [31:0]   fetch_pc;
  logic [AW-1:0] imem_rd_addr;
  logic          fetch_valid;
  logic          core_stall;
  logic          load_done;
  logic          fetch_fault;
  logic [31:0]   fault_pc;

  // core / boot loader / memory side
  modport master (
    output load_start, load_len, ld_valid, ld_data, fetch_pc,
    input  ld_ready, imem_wr_en, imem_wr_addr, imem_wr_data, imem_rd_addr,
           fetch_valid, core_stall, load_done, fetch_fault, fault_pc
  );

  // controller side
  modport slave (
    input  load_start, load_len, ld_valid, ld_data, fetch_pc,
    output ld_ready, imem_wr_en, imem_wr_addr, imem_wr_data, imem_rd_addr,
           fetch_valid, core_stall, load_done, fetch_fault, fault_pc
  );
endinterface

// File: rtl/risc_v_mike_imem_ctrl.sv
// rtl/risc_v_mike_imem_ctrl.sv - boot-load sequencer and fetch qualifier for instruction memory
module risc_v_mike_imem_ctrl #(
  parameter int IMEM_DEPTH = 1024,
  parameter int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  risc_v_mike_imem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(IMEM_DEPTH);

  state_t        state;
  logic [AW-1:0] counter;
  logic [AW-1:0] len_last;    // index of the final word of the current load
  logic          ld_ready_q;
  logic          core_stall_q;
  logic          load_done_q;
  logic          fetch_fault_q;
  logic [31:0]   fault_pc_q;

  logic [AW:0]   len_eff;
  logic          fetch_bad;
  logic          wr_fire;

  // clamp the requested length to the memory size rather than wrapping it
  assign len_eff = (bus.load_len > DEPTH_W) ? DEPTH_W : bus.load_len;

  // misaligned or beyond the last word of memory
  assign fetch_bad = (bus.fetch_pc[1:0] != 2'b00) ||
                     ({2'b00, bus.fetch_pc[31:2]} >= 32'(IMEM_DEPTH));

  // a word arriving with a restart is dropped, so load_start blocks the write
  assign wr_fire = (state == LOAD) && bus.ld_valid && !bus.load_start;

  assign bus.imem_wr_en   = wr_fire;
  assign bus.imem_wr_addr = counter;
  assign bus.imem_wr_data = wr_fire ? bus.ld_data : 32'h0;
  assign bus.imem_rd_addr = bus.fetch_pc[AW+1:2];
  assign bus.fetch_valid  = (state == RUN) && !fetch_bad;
  assign bus.ld_ready     = ld_ready_q;
  assign bus.core_stall   = core_stall_q;
  assign bus.load_done    = load_done_q;
  assign bus.fetch_fault  = fetch_fault_q;
  assign bus.fault_pc     = fault_pc_q;

  // state sequencing with registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      counter       <= '0;
      len_last      <= '0;
      ld_ready_q    <= 1'b0;
      core_stall_q  <= 1'b1;
      load_done_q   <= 1'b0;
      fetch_fault_q <= 1'b0;
      fault_pc_q    <= 32'h0;
    end else begin
      load_done_q <= 1'b0;
      if (bus.load_start) begin
        // (re)start from any state: clear progress and any latched fault
        counter       <= '0;
        len_last      <= AW'(len_eff - 1'b1);
        fetch_fault_q <= 1'b0;
        fault_pc_q    <= 32'h0;
        if (len_eff != '0) begin
          state        <= LOAD;
          ld_ready_q   <= 1'b1;
          core_stall_q <= 1'b1;
        end else begin
          state        <= RUN;
          ld_ready_q   <= 1'b0;
          core_stall_q <= 1'b0;
          load_done_q  <= 1'b1;
        end
      end else begin
        case (state)
          LOAD: begin
            if (bus.ld_valid) begin
              counter <= counter + 1'b1;
              if (counter == len_last) begin
                state        <= RUN;
                ld_ready_q   <= 1'b0;
                core_stall_q <= 1'b0;
                load_done_q  <= 1'b1;
              end
            end
          end
          RUN: begin
            if (fetch_bad) begin
              state         <= FAULT;
              core_stall_q  <= 1'b1;
              fetch_fault_q <= 1'b1;
              fault_pc_q    <= bus.fetch_pc;
            end
          end
          default: begin
            // IDLE and FAULT wait for load_start
          end
        endcase
      end
    end
  end

endmodule

// File: doc/risc_v_mike_imem_ctrl.md
# risc_v_mike_imem_ctrl

Instruction-memory controller for the risc_v_mike core. It sits between the core fetch stage, a boot-load word stream and the instruction memory. It sequences the program load into the memory write port while holding the core stalled. It then releases the core and qualifies every fetch, latching a sticky fault on any misaligned or out-of-range PC.

## Interface
Parameters:
- IMEM_DEPTH, 1024, instruction memory depth in 32-bit words
- AW, $clog2(IMEM_DEPTH), word-index width

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- load_start  in  1  single-cycle pulse that begins a (re)load
- load_len  in  AW+1  number of words to load, sampled with load_start
- ld_valid  in  1  load word valid
- ld_data  in  32  load word
- ld_ready  out  1  controller accepts ld_data this cycle
- imem_wr_en  out  1  memory write strobe
- imem_wr_addr  out  AW  memory write word index
- imem_wr_data  out  32  memory write data
- fetch_pc  in  32  core fetch byte address (t_pc_addr)
- imem_rd_addr  out  AW  memory read word index, equal to fetch_pc[AW+1:2]
- fetch_valid  out  1  fetched word is legal this cycle
- core_stall  out  1  core must hold its PC and pipeline
- load_done  out  1  one-cycle pulse after the last word is written
- fetch_fault  out  1  sticky fault flag
- fault_pc  out  32  fetch_pc captured at fault

## Operation
- FSM states are IDLE, LOAD, RUN and FAULT. Reset enters IDLE.
- IDLE:
  - core_stall=1; ld_ready=0.
  - load_start with len_eff>0 -> LOAD, word counter cleared.
  - load_start with len_eff=0 -> RUN, with load_done pulsed.
- len_eff = min(load_len, IMEM_DEPTH). Values above IMEM_DEPTH are clamped, never wrapped.
- LOAD:
  - ld_ready=1 and core_stall=1.
  - Each cycle with ld_valid&ld_ready sets imem_wr_en=1, imem_wr_addr=counter and imem_wr_data=ld_data (combinational pass). The counter then increments.
  - On the transfer where counter==len_eff-1, the next state is RUN and load_done pulses in the first RUN cycle.
  - Cycles with ld_valid=0 write nothing and hold the counter.
- RUN:
  - core_stall=0.
  - fetch_valid=1 unless the fetch is bad. A fetch is bad when fetch_pc[1:0]!=0 or (fetch_pc>>2)>=IMEM_DEPTH.
  - A bad fetch forces fetch_valid=0 that same cycle. The next state is FAULT, with fetch_fault=1 and fault_pc=fetch_pc registered.
- FAULT:
  - core_stall=1; fetch_valid=0; fault state holds.
  - Only load_start (-> LOAD, or RUN if len_eff=0) or rst exits.
  - fetch_fault and fault_pc clear on load_start.
- load_start in LOAD or RUN restarts the load: counter=0 and len_eff is resampled.
  - A word transferred in that same cycle is discarded, and no write occurs.
  - The stall is reasserted from the next cycle.
- imem_rd_addr is always fetch_pc[AW+1:2], combinational and independent of state.
- imem_wr_en is 0 outside LOAD.

## Timing
- Reset values:
  - state=IDLE, counter=0.
  - core_stall=1; ld_ready=0; imem_wr_en=0; imem_wr_addr=0; imem_wr_data=0.
  - fetch_valid=0; load_done=0; fetch_fault=0; fault_pc=0.
- ld_valid/ld_ready handshake:
  - ld_data must be held until accepted.
  - ld_ready depends only on state, with no combinational path from ld_valid.
- Write latency: 0 cycles. The write is visible at the memory on the accepting clock edge.
- A load of N words with ld_valid held high takes N cycles in LOAD. core_stall falls on cycle N+1 after load_start, which is also the load_done cycle.
- Fault detection is combinational in the offending cycle. Flag and capture are registered on the following edge.
- rst mid-LOAD aborts immediately with no further writes. Memory contents are untouched by the controller.

## Test plan
- Reset, then load_start with load_len=3 and words 0x00f00093, 0x00800113, 0x002081b3 streamed back-to-back -> three writes to addresses 0,1,2; load_done high in cycle 4; core_stall low from cycle 4.
- Load with gaps (ld_valid toggling 1,0,1,0,1, len=3) -> writes only on valid cycles; the counter holds during gaps; RUN follows the third transfer.
- load_len=2000 with IMEM_DEPTH=1024 -> exactly 1024 writes, last address 1023, then RUN.
- In RUN, fetch_pc=0x00000006 -> fetch_valid=0 that cycle; next cycle fetch_fault=1, fault_pc=0x6, core_stall=1. Then load_start with len=0 -> fault cleared, RUN, load_done pulse.
- In RUN, fetch_pc=0x00001000 (word 1024) -> fault. fetch_pc=0x00000FFC -> fetch_valid=1 with imem_rd_addr=1023.
- rst asserted after the 2nd of 5 words, then released and a new load_start with len=1 -> no writes during reset; the new load writes address 0 only.
